// File: rtl/qam16_mapper_if.sv
// Bit-stream handshake and symbol output bundle
// for the 16QAM mapper.
interface qam16_mapper_if #(
  parameter int DEPTH = 8
);
  logic                    bit_in;
  logic                    bit_valid;
  logic                    bit_ready;
  logic [7:0]              I_out;
  logic [7:0]              Q_out;
  logic                    sym_valid;
  logic                    underrun;
  logic [$clog2(DEPTH):0]  fifo_level;

  modport master (
    output bit_in,
    output bit_valid,
    input  bit_ready,
    input  I_out,
    input  Q_out,
    input  sym_valid,
    input  underrun,
    input  fifo_level
  );

  modport slave (
    input  bit_in,
    input  bit_valid,
    output bit_ready,
    output I_out,
    output Q_out,
    output sym_valid,
    output underrun,
    output fifo_level
  );
endinterface

// File: rtl/qam16_mapper.sv
// 16QAM hard-constellation mapper: serial bits in,
// nibble FIFO, Gray-mapped signed I/Q levels out.
module qam16_mapper #(
  parameter int DEPTH   = 8,
  parameter int SYM_DIV = 4,
  parameter int PREFILL = 2,
  parameter int LVL_HI  = 96,
  parameter int LVL_LO  = 32
) (
  input  logic           symbol_clock,
  input  logic           rst,
  input  logic           en,
  qam16_mapper_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int DW = (SYM_DIV > 1) ? $clog2(SYM_DIV) : 1;

  typedef enum logic [1:0] {
    IDLE, FILL, RUN, DRAIN
  } state_t;

  state_t         state_q, state_d;
  logic [1:0]     cnt_q, cnt_d;
  logic [2:0]     nib_q, nib_d;
  logic [DW-1:0]  div_q, div_d;
  logic [AW-1:0]  wr_q, wr_d;
  logic [AW-1:0]  rd_q, rd_d;
  logic [LW-1:0]  lvl_q, lvl_d;
  logic [7:0]     i_q, i_d;
  logic [7:0]     qo_q, qo_d;
  logic           sv_q, sv_d;
  logic           ur_q, ur_d;
  logic [3:0]     mem_q [DEPTH];

  logic           full, empty, ready;
  logic           accept, push, strobe, pop;
  logic [3:0]     head, nib_full;

  function automatic logic [7:0] level(
    input logic pos,
    input logic lo
  );
    logic [7:0] m;
    m = lo ? 8'(LVL_LO) : 8'(LVL_HI);
    return pos ? m : (~m + 8'd1);
  endfunction

  assign full     = lvl_q == LW'(DEPTH);
  assign empty    = lvl_q == '0;
  assign ready    = (state_q == FILL ||
                     state_q == RUN) &&
                    !(full && cnt_q == 2'd3);
  assign accept   = bus.bit_valid && ready;
  assign push     = accept && cnt_q == 2'd3;
  assign strobe   = (state_q == RUN ||
                     state_q == DRAIN) &&
                    div_q == DW'(SYM_DIV - 1);
  assign pop      = strobe && !empty;
  assign head     = mem_q[rd_q];
  assign nib_full = {bus.bit_in, nib_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    nib_d   = nib_q;
    div_d   = div_q;
    wr_d    = wr_q + AW'(push);
    rd_d    = rd_q + AW'(pop);
    lvl_d   = lvl_q + LW'(push) - LW'(pop);
    i_d     = i_q;
    qo_d    = qo_q;
    sv_d    = 1'b0;
    ur_d    = 1'b0;
    if (accept) begin
      if (cnt_q == 2'd3) begin
        cnt_d = 2'd0;
        nib_d = 3'd0;
      end else begin
        cnt_d = cnt_q + 2'd1;
        nib_d = nib_q |
                (3'(bus.bit_in) << cnt_q);
      end
    end
    // n[3]/n[1] pick sign, n[2]/n[0] pick inner ring
    if (pop) begin
      i_d  = level(head[3], head[2]);
      qo_d = level(!head[1], head[0]);
      sv_d = 1'b1;
    end
    unique case (state_q)
      IDLE: begin
        div_d = '0;
        if (en) state_d = FILL;
      end
      FILL: begin
        div_d = '0;
        if (!en) begin
          state_d = IDLE;
          wr_d    = '0;
          rd_d    = '0;
          lvl_d   = '0;
          cnt_d   = 2'd0;
          nib_d   = 3'd0;
        end else if (lvl_d >= LW'(PREFILL)) begin
          state_d = RUN;
        end
      end
      RUN: begin
        div_d = strobe ? '0 : div_q + DW'(1);
        if (strobe && empty) begin
          i_d  = 8'd0;
          qo_d = 8'd0;
          ur_d = 1'b1;
        end
        if (!en) begin
          state_d = DRAIN;
          cnt_d   = 2'd0;
          nib_d   = 3'd0;
        end
      end
      DRAIN: begin
        div_d = strobe ? '0 : div_q + DW'(1);
        if (strobe && empty) begin
          state_d = IDLE;
          i_d     = 8'd0;
          qo_d    = 8'd0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge symbol_clock) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      nib_q   <= 3'd0;
      div_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      lvl_q   <= '0;
      i_q     <= 8'd0;
      qo_q    <= 8'd0;
      sv_q    <= 1'b0;
      ur_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      nib_q   <= nib_d;
      div_q   <= div_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      lvl_q   <= lvl_d;
      i_q     <= i_d;
      qo_q    <= qo_d;
      sv_q    <= sv_d;
      ur_q    <= ur_d;
    end
  end

  always_ff @(posedge symbol_clock) begin
    if (!rst && push) mem_q[wr_q] <= nib_full;
  end

  assign bus.bit_ready  = ready;
  assign bus.I_out      = i_q;
  assign bus.Q_out      = qo_q;
  assign bus.sym_valid  = sv_q;
  assign bus.underrun   = ur_q;
  assign bus.fifo_level = lvl_q;
endmodule
